parity_frame_checker: RTL and testbench

- Streaming parity checker for the switch/LED lab designs.
- Accepts frames of FRAME_LEN data words, each with a row parity bit, followed by one longitudinal (column) parity word.
- Checks row parity per word and column parity per frame, in even or odd mode.
- Keeps error counters and a sticky error flag, and drives the RGB0 LED with frame status.

---
 rtl/parity_frame_checker.sv | 152 +++++++++++++++
 tb/tb_parity_frame_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Streaming row/column parity checker: FRAME_LEN data words, then one LRC word, then a one-cycle report slot.
// Optional PARITY_CNT_SAT_EN makes the error counters saturate instead of wrapping.
module parity_frame_checker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_odd,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] row_err_cnt,
    output logic [CNT_W-1:0] lrc_err_cnt,
    output logic             err_sticky,
    output logic [2:0]       RGB0
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_DATA, S_LRC, S_REPORT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               mode_q, mode_d;
    logic               row_flag_q, row_flag_d;
    logic               in_ready_q, in_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_ok_q, frame_ok_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]   lrc_cnt_q, lrc_cnt_d;
    logic               sticky_q, sticky_d;
    logic               busy_q, busy_d;

    logic accept, first, eff_mode, row_bad, lrc_bad;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef PARITY_CNT_SAT_EN
        return (&c) ? c : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    always_comb begin
        accept   = in_valid && in_ready_q;
        first    = (state_q == S_DATA) && (idx_q == '0);
        // Word 0 is checked against the mode presented with it, not the stale latched one.
        eff_mode = first ? mode_odd : mode_q;
        row_bad  = accept && (in_par != ((^in_data) ^ eff_mode));
        lrc_bad  = accept && (state_q == S_LRC) && (in_data != (acc_q ^ {WIDTH{mode_q}}));

        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        row_flag_d   = row_flag_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;

        case (state_q)
            S_DATA: begin
                if (accept) begin
                    if (first) begin
                        mode_d     = mode_odd;
                        acc_d      = in_data;
                        row_flag_d = row_bad;
                    end else begin
                        acc_d      = acc_q ^ in_data;
                        row_flag_d = row_flag_q | row_bad;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_LRC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LRC: begin
                if (accept) begin
                    state_d      = S_REPORT;
                    frame_done_d = 1'b1;
                    frame_ok_d   = !(row_flag_q || row_bad) && !lrc_bad;
                    idx_d        = '0;
                    acc_d        = '0;
                    row_flag_d   = 1'b0;
                end
            end
            S_REPORT: begin
                state_d    = S_DATA;
                idx_d      = '0;
                acc_d      = '0;
                row_flag_d = 1'b0;
            end
            default: state_d = S_DATA;
        endcase

        in_ready_d = (state_d != S_REPORT);
        busy_d     = (idx_d != '0) || (state_d == S_LRC);

        // clr has priority over a coincident increment.
        row_cnt_d = clr ? '0 : (row_bad ? cnt_inc(row_cnt_q) : row_cnt_q);
        lrc_cnt_d = clr ? '0 : (lrc_bad ? cnt_inc(lrc_cnt_q) : lrc_cnt_q);
        sticky_d  = clr ? 1'b0 : (sticky_q | row_bad | lrc_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DATA;
            idx_q        <= '0;
            acc_q        <= '0;
            mode_q       <= 1'b0;
            row_flag_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            row_cnt_q    <= '0;
            lrc_cnt_q    <= '0;
            sticky_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            row_flag_q   <= row_flag_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            row_cnt_q    <= row_cnt_d;
            lrc_cnt_q    <= lrc_cnt_d;
            sticky_q     <= sticky_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign row_err_cnt = row_cnt_q;
    assign lrc_err_cnt = lrc_cnt_q;
    assign err_sticky  = sticky_q;
    assign RGB0        = {busy_q, sticky_q, frame_ok_q};

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (WIDTH=8, FRAME_LEN=4, CNT_W=2).
// Expected values are hand-computed per step.
module tb_parity_frame_checker;
    logic       clk, rst_n, mode_odd, clr, in_valid, in_ready, in_par;
    logic [7:0] in_data;
    logic       frame_done, frame_ok, err_sticky;
    logic [1:0] row_err_cnt, lrc_err_cnt;
    logic [2:0] RGB0;
    int total = 0;
    int bad   = 0;

    parity_frame_checker #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode_odd), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
        .frame_done(frame_done), .frame_ok(frame_ok), .row_err_cnt(row_err_cnt),
        .lrc_err_cnt(lrc_err_cnt), .err_sticky(err_sticky), .RGB0(RGB0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, wait for in_ready (bounded), return just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic p);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed=in_ready_low expected=in_ready_high");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_par   = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; mode_odd = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_par = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rgb", RGB0, 3'b000);
        chk("rst_row", row_err_cnt, 0);
        chk("rst_done", frame_done, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Clean even frame
        send(8'h01, 1'b1);
        chk("busy_mid_frame", RGB0, 3'b100);
        send(8'h02, 1'b1);
        send(8'h04, 1'b1);
        send(8'h08, 1'b1);
        send(8'h0F, 1'b0);
        chk("a_done", frame_done, 1);
        chk("a_ok", frame_ok, 1);
        chk("a_row", row_err_cnt, 0);
        chk("a_lrc", lrc_err_cnt, 0);
        chk("a_rgb", RGB0, 3'b001);
        chk("a_report_ready", in_ready, 0);
        step();
        chk("a_done_pulse", frame_done, 0);
        chk("a_ok_hold", frame_ok, 1);

        // Row error on word 1 (0x03 has even parity); LRC 0x0E matches the XOR
        send(8'h01, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        send(8'h08, 1'b1);
        send(8'h0E, 1'b1);
        chk("b_row", row_err_cnt, 1);
        chk("b_lrc", lrc_err_cnt, 0);
        chk("b_ok", frame_ok, 0);
        chk("b_rgb", RGB0, 3'b010);

        // clr zeroes counters and sticky, leaves frame_ok
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_row", row_err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        chk("clr_ok_hold", frame_ok, 0);

        // Odd mode: zeros with par=1, LRC 0xFF
        mode_odd = 1'b1;
        repeat (4) send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        chk("c_ok", frame_ok, 1);
        chk("c_lrc", lrc_err_cnt, 0);
        // Same, LRC 0xFE par=0: row fine, LRC mismatch
        repeat (4) send(8'h00, 1'b1);
        send(8'hFE, 1'b0);
        chk("d_ok", frame_ok, 0);
        chk("d_lrc", lrc_err_cnt, 1);
        chk("d_row", row_err_cnt, 0);
        chk("d_sticky", err_sticky, 1);

        // Handshake gaps; mode flips after word 0 and must be ignored
        mode_odd = 1'b0;
        send(8'h01, 1'b1);
        mode_odd = 1'b1;
        idle();
        send(8'h02, 1'b1);
        idle();
        send(8'h04, 1'b1);
        idle();
        send(8'h08, 1'b1);
        idle();
        chk("e_busy_idle", RGB0[2], 1);
        send(8'h0F, 1'b0);
        chk("e_ok", frame_ok, 1);
        chk("e_row", row_err_cnt, 0);
        chk("e_lrc", lrc_err_cnt, 1);

        // Word held through REPORT becomes index 0 of an odd frame
        in_valid = 1'b1; in_data = 8'h01; in_par = 1'b0;
        step();
        chk("f_not_taken_in_report", RGB0[2], 0);
        chk("f_ready_after_report", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("f_taken", RGB0[2], 1);
        mode_odd = 1'b0;
        repeat (3) send(8'h00, 1'b1);
        send(8'hFE, 1'b0);
        chk("f_ok", frame_ok, 1);
        chk("f_row", row_err_cnt, 0);

        // Async reset mid-frame
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("g_rst_rgb", RGB0, 3'b000);
        chk("g_rst_lrc", lrc_err_cnt, 0);
        chk("g_rst_sticky", err_sticky, 0);
        chk("g_rst_ready", in_ready, 0);
        #3;
        rst_n = 1'b1;
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h04, 1'b1);
        send(8'h08, 1'b1);
        send(8'h0F, 1'b0);
        chk("g_ok", frame_ok, 1);
        chk("g_row", row_err_cnt, 0);
        chk("g_done", frame_done, 1);

        // clr coinciding with a row-error increment
        send(8'h01, 1'b0);
        chk("h_row_1", row_err_cnt, 1);
        clr = 1'b1;
        send(8'h02, 1'b0);
        clr = 1'b0;
        chk("h_clr_wins", row_err_cnt, 0);
        chk("h_clr_sticky", err_sticky, 0);
        send(8'h04, 1'b1);
        send(8'h08, 1'b1);
        send(8'h0F, 1'b0);
        chk("h_ok_frame_flag_kept", frame_ok, 0);
        chk("h_lrc", lrc_err_cnt, 0);

        // Five row errors with a 2-bit counter
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        send(8'h08, 1'b0);
        send(8'h0F, 1'b1);
`ifdef PARITY_CNT_SAT_EN
        chk("i_row_overflow", row_err_cnt, 3);
`else
        chk("i_row_overflow", row_err_cnt, 1);
`endif
        chk("i_lrc", lrc_err_cnt, 0);
        chk("i_sticky", err_sticky, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
